regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/kgp_risc_pkg.sv | 33 +++
 rtl/regfile_wb_arbiter_if.sv | 35 +++
 rtl/wb_arb2.sv | 87 ++++++++
 rtl/regfile_wb_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/kgp_risc_pkg.sv
// -----------------------------------------------------------------------------
// kgp_risc_pkg
// Shared widths and types for the register-file writeback path.
//   REG_ADDR_W : register-file address width
//   DATA_W     : register-file data width
//   WR_CNT_W   : committed-write counter width
// Also provides the writeback request record, the grant-select encoding
// used by the arbiter pointer, and the wrapping counter increment.
// -----------------------------------------------------------------------------
package kgp_risc_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int WR_CNT_W   = 16;

    // Destination register plus data, as captured at handshake.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    // Which requester won the most recent handshake.
    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_sel_e;

    // Counter increment; natural modulo-2^WR_CNT_W wrap.
    function automatic logic [WR_CNT_W-1:0] wr_count_inc(input logic [WR_CNT_W-1:0] cnt);
        return cnt + {{(WR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Two writeback requesters (req0 = ALU, req1 = load) with valid/ready
// handshakes, destination register and data.
//   modport master : requester side (drives valid/reg/data, sees ready)
//   modport slave  : arbiter side (sees valid/reg/data, drives ready)
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
    import kgp_risc_pkg::*;

    logic                  req0_valid;
    logic                  req0_ready;
    logic [REG_ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0]     req0_data;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [REG_ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0]     req1_data;

    modport master (
        output req0_valid, req0_reg, req0_data,
        input  req0_ready,
        output req1_valid, req1_reg, req1_data,
        input  req1_ready
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        output req0_ready,
        input  req1_valid, req1_reg, req1_data,
        output req1_ready
    );

endinterface

// File: rtl/wb_arb2.sv
// -----------------------------------------------------------------------------
// wb_arb2
// Two-way writeback grant logic. Ready outputs are combinational from valid,
// stall, reset and (optionally) the last-grant pointer.
// Build option: WB_ARB_RR_EN
//   undefined : fixed priority, req0 over req1, no state, no clock
//   defined   : round-robin on contest, pointer updated on handshake only
// Ports:
//   clk     : clock (WB_ARB_RR_EN only)
//   reset   : asynchronous active-low reset; also gates both readies low
//   stall   : blocks every grant while high
//   valid0/1: requester valids
//   ready0/1: one-hot-or-zero grants (a grant equals a handshake)
// -----------------------------------------------------------------------------
module wb_arb2
    import kgp_risc_pkg::*;
(
`ifdef WB_ARB_RR_EN
    input  logic clk,
`endif
    input  logic reset,
    input  logic stall,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1
);

    logic grant0_s;
    logic grant1_s;

`ifdef WB_ARB_RR_EN
    grant_sel_e last_grant_r;

    // Round-robin choice: on contest favour whoever did not win last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (valid0 && valid1) begin
            if (last_grant_r == GRANT_REQ1) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (valid0) begin
            grant0_s = 1'b1;
        end else if (valid1) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Last-grant pointer; reset value makes req0 win the first contest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= GRANT_REQ1;
        end else if (ready0) begin
            last_grant_r <= GRANT_REQ0;
        end else if (ready1) begin
            last_grant_r <= GRANT_REQ1;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Fixed priority: req1 only when req0 is idle.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (valid0) begin
            grant0_s = 1'b1;
        end else if (valid1) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end
`endif

    // Stall and active reset suppress both grants.
    assign ready0 = grant0_s & ~stall & reset;
    assign ready1 = grant1_s & ~stall & reset;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates ALU and load writebacks onto a single register-file write port.
// A handshake in cycle N produces regwrite=1 with the winner's reg/data in
// cycle N+1; one handshake per cycle is sustained.
// Build option: WB_ARB_RR_EN selects round-robin instead of fixed priority
// (implemented inside wb_arb2).
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   wb        : requester handshakes (slave modport)
//   stall     : blocks new grants while high
//   writereg  : registered write address (holds when idle)
//   writedata : registered write data (holds when idle)
//   regwrite  : registered write strobe
//   wr_count  : committed-write counter, wraps
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import kgp_risc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   wb,
    input  logic                  stall,
    output logic [REG_ADDR_W-1:0] writereg,
    output logic [DATA_W-1:0]     writedata,
    output logic                  regwrite,
    output logic [WR_CNT_W-1:0]   wr_count
);

    logic    ready0_s;
    logic    ready1_s;
    logic    hs_s;
    wb_req_t win_s;

    logic [REG_ADDR_W-1:0] writereg_r;
    logic [DATA_W-1:0]     writedata_r;
    logic                  regwrite_r;
    logic [WR_CNT_W-1:0]   wr_count_r;

    wb_arb2 u_arb (
`ifdef WB_ARB_RR_EN
        .clk    (clk),
`endif
        .reset  (reset),
        .stall  (stall),
        .valid0 (wb.req0_valid),
        .valid1 (wb.req1_valid),
        .ready0 (ready0_s),
        .ready1 (ready1_s)
    );

    assign wb.req0_ready = ready0_s;
    assign wb.req1_ready = ready1_s;

    // Ready already includes valid, so any ready is a handshake.
    assign hs_s = ready0_s | ready1_s;

    // Select the winning requester's payload.
    always_comb begin
        win_s = '0;
        if (ready0_s) begin
            win_s.reg_addr = wb.req0_reg;
            win_s.data     = wb.req0_data;
        end else begin
            win_s.reg_addr = wb.req1_reg;
            win_s.data     = wb.req1_data;
        end
    end

    // Write-port register and commit counter; reset drops any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite_r  <= 1'b0;
            writereg_r  <= '0;
            writedata_r <= '0;
            wr_count_r  <= '0;
        end else begin
            regwrite_r <= hs_s;
            if (hs_s) begin
                writereg_r  <= win_s.reg_addr;
                writedata_r <= win_s.data;
                wr_count_r  <= wr_count_inc(wr_count_r);
            end else begin
                writereg_r  <= writereg_r;
                writedata_r <= writedata_r;
                wr_count_r  <= wr_count_r;
            end
        end
    end

    assign writereg  = writereg_r;
    assign writedata = writedata_r;
    assign regwrite  = regwrite_r;
    assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed table of one-cycle vectors (readies checked before the edge,
// registered outputs just after it), then hand-written sequences for reset
// during a pending write and counter wrap.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    import kgp_risc_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  stall;
    logic [REG_ADDR_W-1:0] writereg;
    logic [DATA_W-1:0]     writedata;
    logic                  regwrite;
    logic [WR_CNT_W-1:0]   wr_count;

    regfile_wb_arbiter_if wb_if ();

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .wb        (wb_if),
        .stall     (stall),
        .writereg  (writereg),
        .writedata (writedata),
        .regwrite  (regwrite),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_rw;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sv(input int idx, input logic st,
                      input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                      input logic e_rdy0, input logic e_rdy1, input logic e_rw,
                      input logic [4:0] e_reg, input logic [31:0] e_data,
                      input logic [15:0] e_cnt);
        vecs[idx] = '{st, v0, r0, d0, v1, r1, d1, e_rdy0, e_rdy1, e_rw, e_reg, e_data, e_cnt};
    endtask

    task automatic drive(input logic st, input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        stall            = st;
        wb_if.req0_valid = v0;
        wb_if.req0_reg   = r0;
        wb_if.req0_data  = d0;
        wb_if.req1_valid = v1;
        wb_if.req1_reg   = r1;
        wb_if.req1_data  = d1;
    endtask

    initial begin
        int bad;
        logic [15:0] cnt_model;

        //   idx st v0 r0     d0             v1 r1     d1            rdy0 rdy1 rw   reg    data           cnt
        sv(0,  1'b0, 1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b0, 5'd0,  32'd0,   16'd0);
`ifdef WB_ARB_RR_EN
        sv(1,  1'b0, 1'b1, 5'd10, 32'd100, 1'b1, 5'd10, 32'd7,   1'b1, 1'b0, 1'b1, 5'd10, 32'd100, 16'd1);
        sv(2,  1'b0, 1'b1, 5'd10, 32'd100, 1'b1, 5'd10, 32'd7,   1'b0, 1'b1, 1'b1, 5'd10, 32'd7,   16'd2);
        sv(3,  1'b0, 1'b1, 5'd10, 32'd100, 1'b1, 5'd10, 32'd7,   1'b1, 1'b0, 1'b1, 5'd10, 32'd100, 16'd3);
        sv(4,  1'b0, 1'b1, 5'd10, 32'd100, 1'b1, 5'd10, 32'd7,   1'b0, 1'b1, 1'b1, 5'd10, 32'd7,   16'd4);
        sv(5,  1'b0, 1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b0, 5'd10, 32'd7,   16'd4);
`else
        sv(1,  1'b0, 1'b1, 5'd10, 32'd100, 1'b1, 5'd10, 32'd7,   1'b1, 1'b0, 1'b1, 5'd10, 32'd100, 16'd1);
        sv(2,  1'b0, 1'b1, 5'd10, 32'd100, 1'b1, 5'd10, 32'd7,   1'b1, 1'b0, 1'b1, 5'd10, 32'd100, 16'd2);
        sv(3,  1'b0, 1'b1, 5'd10, 32'd100, 1'b1, 5'd10, 32'd7,   1'b1, 1'b0, 1'b1, 5'd10, 32'd100, 16'd3);
        sv(4,  1'b0, 1'b1, 5'd10, 32'd100, 1'b1, 5'd10, 32'd7,   1'b1, 1'b0, 1'b1, 5'd10, 32'd100, 16'd4);
        sv(5,  1'b0, 1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b0, 5'd10, 32'd100, 16'd4);
`endif
        sv(6,  1'b0, 1'b1, 5'd2,  32'd55,  1'b0, 5'd0,  32'd0,   1'b1, 1'b0, 1'b1, 5'd2,  32'd55,  16'd5);
        sv(7,  1'b0, 1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b0, 5'd2,  32'd55,  16'd5);
        sv(8,  1'b1, 1'b0, 5'd0,  32'd0,   1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd2, 32'd55, 16'd5);
        sv(9,  1'b1, 1'b0, 5'd0,  32'd0,   1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd2, 32'd55, 16'd5);
        sv(10, 1'b1, 1'b0, 5'd0,  32'd0,   1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd2, 32'd55, 16'd5);
        sv(11, 1'b0, 1'b0, 5'd0,  32'd0,   1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 16'd6);
        sv(12, 1'b0, 1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b0, 5'd7,  32'hDEADBEEF, 16'd6);
        sv(13, 1'b0, 1'b1, 5'd3,  32'd33,  1'b0, 5'd0,  32'd0,   1'b1, 1'b0, 1'b1, 5'd3,  32'd33,  16'd7);
        sv(14, 1'b1, 1'b1, 5'd4,  32'd44,  1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b0, 5'd3,  32'd33,  16'd7);
        sv(15, 1'b0, 1'b0, 5'd0,  32'd0,   1'b1, 5'd0,  32'd5,   1'b0, 1'b1, 1'b1, 5'd0,  32'd5,   16'd8);
        sv(16, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 16'd9);
        sv(17, 1'b0, 1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 16'd9);

        // Reset asserted for 20 ns; readies must stay low even with a valid.
        reset = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #10;
        chk("reset_regwrite", {31'd0, regwrite}, 32'd0);
        chk("reset_wr_count", {16'd0, wr_count}, 32'd0);
        wb_if.req0_valid = 1'b1;
        #1;
        chk("reset_ready0_low", {31'd0, wb_if.req0_ready}, 32'd0);
        wb_if.req0_valid = 1'b0;
        #9;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table: drive, check readies, clock, check registered outputs.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].st, vecs[i].v0, vecs[i].r0, vecs[i].d0, vecs[i].v1, vecs[i].r1, vecs[i].d1);
            #1;
            chk($sformatf("v%0d_ready0", i), {31'd0, wb_if.req0_ready}, {31'd0, vecs[i].e_rdy0});
            chk($sformatf("v%0d_ready1", i), {31'd0, wb_if.req1_ready}, {31'd0, vecs[i].e_rdy1});
            if (i == 14) begin
                // Write registered before stall rose is still presented.
                chk("stall_rise_pending_write", {31'd0, regwrite}, 32'd1);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_regwrite", i), {31'd0, regwrite}, {31'd0, vecs[i].e_rw});
            chk($sformatf("v%0d_writereg", i), {27'd0, writereg}, {27'd0, vecs[i].e_reg});
            chk($sformatf("v%0d_writedata", i), writedata, vecs[i].e_data);
            chk($sformatf("v%0d_wr_count", i), {16'd0, wr_count}, {16'd0, vecs[i].e_cnt});
        end

        // Handshake, then reset before the edge that would have issued more.
        drive(1'b0, 1'b1, 5'd9, 32'd99, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_hs_regwrite", {31'd0, regwrite}, 32'd1);
        chk("mid_hs_wr_count", {16'd0, wr_count}, 32'd10);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("mid_rst_writereg", {27'd0, writereg}, 32'd0);
        chk("mid_rst_writedata", writedata, 32'd0);
        chk("mid_rst_wr_count", {16'd0, wr_count}, 32'd0);
        chk("mid_rst_ready0", {31'd0, wb_if.req0_ready}, 32'd0);
        wb_if.req0_valid = 1'b0;
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("post_rst_wr_count", {16'd0, wr_count}, 32'd0);

        // 65536 back-to-back handshakes from req0: counter wraps to zero.
        bad = 0;
        cnt_model = 16'd0;
        for (int i = 0; i < 65536; i++) begin
            drive(1'b0, 1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'd0);
            @(posedge clk);
            #1;
            cnt_model = cnt_model + 16'd1;
            if (regwrite !== 1'b1 || writedata !== 32'(i) || writereg !== 5'(i) || wr_count !== cnt_model) begin
                if (bad < 4) begin
                    $display("FAIL wrap_step%0d regwrite=%0b data=%0h cnt=%0h required rw=1 data=%0h cnt=%0h",
                             i, regwrite, writedata, wr_count, i, cnt_model);
                end
                bad++;
            end
        end
        chk("wrap_bad_cycles", 32'(bad), 32'd0);
        chk("wrap_wr_count_zero", {16'd0, wr_count}, 32'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        chk("wrap_idle_regwrite", {31'd0, regwrite}, 32'd0);
        chk("wrap_idle_wr_count", {16'd0, wr_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
